// File: rtl/nts_bram_pkg.sv
// Shared constants and state encoding for the NTS block RAM write stage.
package nts_bram_pkg;

  localparam int BLOCK_WIDTH = 128;
  localparam int WORD_WIDTH  = 64;
  localparam int GAP_CYCLES  = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL_HI  = 3'd1,
    ST_FILL_LO  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

endpackage

// File: rtl/bram_with_ack.sv
// 128-bit block RAM with a cs/we/ack write handshake; ack follows each cs cycle once
// ack_delay consecutive cs cycles have elapsed. Combinational read port for inspection.
module bram_with_ack
  import nts_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   cs,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [BLOCK_WIDTH-1:0] block_wr,
  input  logic [1:0]             ack_delay,
  output logic                   ack,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [BLOCK_WIDTH-1:0] rd_data
);

  logic [BLOCK_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic [1:0]             cnt_r;
  logic                   ack_r;

  // Storage, cs-cycle counter and registered acknowledge
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ack_r <= 1'b0;
      cnt_r <= 2'd0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (cs && we) begin
      if (cnt_r >= ack_delay) begin
        mem_r[addr] <= block_wr;
        ack_r       <= 1'b1;
      end else begin
        ack_r <= 1'b0;
      end
      if (cnt_r != 2'd3) begin
        cnt_r <= cnt_r + 2'd1;
      end
    end else begin
      ack_r <= 1'b0;
      cnt_r <= 2'd0;
    end
  end

  assign ack     = ack_r;
  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/bram_block_loader.sv
// Packs 64-bit word pairs into 128-bit blocks and writes them to consecutive RAM
// addresses through a cs/we/ack handshake, flagging address overflow.
module bram_block_loader
  import nts_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH:0]    blocks_written,
  output logic                   mem_cs,
  output logic                   mem_we,
  input  logic                   mem_ack,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [BLOCK_WIDTH-1:0] mem_block_wr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [1:0]            GAP_LAST  = 2'(GAP_CYCLES - 1);

  state_t                 state_r, state_s;
  logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
  logic [BLOCK_WIDTH-1:0] block_r, block_s;
  logic [ADDR_WIDTH:0]    count_r, count_s;
  logic [1:0]             gap_r, gap_s;
  logic                   last_r, last_s;
  logic                   wrap_r, wrap_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;
  logic                   error_r, error_s;
  logic                   cs_r, cs_s;
  logic                   we_r;

  // Next-state and next-output decode
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    block_s = block_r;
    count_s = count_r;
    gap_s   = gap_r;
    last_s  = last_r;
    wrap_s  = wrap_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    error_s = error_r;
    cs_s    = cs_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          addr_s  = base_addr;
          count_s = '0;
          error_s = 1'b0;
          wrap_s  = 1'b0;
          last_s  = 1'b0;
          busy_s  = 1'b1;
          state_s = ST_FILL_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL_HI: begin
        if (in_valid) begin
          block_s = {in_data, {WORD_WIDTH{1'b0}}};
          if (in_last) begin
            last_s  = 1'b1;
            cs_s    = ~wrap_r;
            state_s = ST_WRITE;
          end else begin
            state_s = ST_FILL_LO;
          end
        end else begin
          state_s = ST_FILL_HI;
        end
      end
      ST_FILL_LO: begin
        if (in_valid) begin
          block_s[WORD_WIDTH-1:0] = in_data;
          last_s  = in_last;
          cs_s    = ~wrap_r;
          state_s = ST_WRITE;
        end else begin
          state_s = ST_FILL_LO;
        end
      end
      ST_WRITE: begin
        // A wrap recorded by the previous ack means there is no address left for this block
        if (wrap_r) begin
          cs_s    = 1'b0;
          error_s = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_ERROR;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (mem_ack) begin
          cs_s    = 1'b0;
          count_s = count_r + COUNT_ONE;
          addr_s  = addr_r + ADDR_ONE;
          wrap_s  = (addr_r == ADDR_TOP) ? 1'b1 : wrap_r;
          gap_s   = 2'd0;
          state_s = ST_GAP;
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_GAP: begin
        if (gap_r != GAP_LAST) begin
          gap_s   = gap_r + 2'd1;
          state_s = ST_GAP;
        end else if (last_r) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_DONE;
        end else begin
          state_s = ST_FILL_HI;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_ERROR: begin
        state_s = ST_IDLE;
      end
      default: begin
        cs_s    = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      block_r <= '0;
      count_r <= '0;
      gap_r   <= 2'd0;
      last_r  <= 1'b0;
      wrap_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      cs_r    <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      block_r <= block_s;
      count_r <= count_s;
      gap_r   <= gap_s;
      last_r  <= last_s;
      wrap_r  <= wrap_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
      cs_r    <= cs_s;
      we_r    <= cs_s;
    end
  end

  assign in_ready       = (state_r == ST_FILL_HI) || (state_r == ST_FILL_LO);
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign blocks_written = count_r;
  assign mem_cs         = cs_r;
  assign mem_we         = we_r;
  assign mem_addr       = addr_r;
  assign mem_block_wr   = block_r;

endmodule

// File: tb/tb_bram_block_loader.sv
// Directed table-driven bench for bram_block_loader with the bram_with_ack RAM model.
module tb_bram_block_loader;

  logic         clk = 1'b0;
  logic         areset, ram_rst;
  logic         start, in_valid, in_ready, in_last;
  logic [3:0]   base_addr;
  logic [63:0]  in_data;
  logic         busy, done, error;
  logic [4:0]   blocks_written;
  logic         mem_cs, mem_we, mem_ack;
  logic [3:0]   mem_addr, rd_addr;
  logic [127:0] mem_block_wr, rd_data;
  logic [1:0]   ack_delay;

  int checks = 0;
  int failures = 0;

  int           done_cnt, acked_cnt, cs_rises, stab_err;
  logic         prev_cs;
  logic [3:0]   prev_addr;
  logic [127:0] prev_data;

  typedef struct {
    logic [3:0]        base;
    int                nwords;
    logic [3:0][63:0]  w;
    logic [1:0]        delay;
    logic [4:0]        exp_blocks;
    logic              exp_done;
    logic              exp_err;
    logic [3:0]        a0;
    logic [127:0]      d0;
    logic [3:0]        a1;
    logic [127:0]      d1;
  } load_vec_t;

  load_vec_t vec [6];

  always #5 clk = ~clk;

  bram_block_loader #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .areset(areset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .busy(busy), .done(done), .error(error), .blocks_written(blocks_written),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_block_wr(mem_block_wr)
  );

  bram_with_ack #(.ADDR_WIDTH(4)) ram (
    .clk(clk), .areset(ram_rst), .cs(mem_cs), .we(mem_we), .addr(mem_addr),
    .block_wr(mem_block_wr), .ack_delay(ack_delay), .ack(mem_ack),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Handshake monitor: done pulses, acked writes, cs rises and cs-phase stability
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_cs && mem_ack) acked_cnt++;
    if (mem_cs && !prev_cs) cs_rises++;
    if (mem_cs && prev_cs && (mem_addr !== prev_addr || mem_block_wr !== prev_data || !mem_we))
      stab_err++;
    prev_cs   = mem_cs;
    prev_addr = mem_addr;
    prev_data = mem_block_wr;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [3:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared_on_start", error, 0);
  endtask

  task automatic feed(input logic [3:0][63:0] w, input int n, input bit spurious);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = (i == n - 1);
      if (spurious && i == 1) begin
        start = 1'b1;
        base_addr = 4'd9;
      end
      t = 0;
      while (!in_ready && t < 60) begin
        tick();
        t++;
      end
      if (!in_ready) chk("word_accept_timeout", 0, 1);
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_load(input int k);
    int t;
    ack_delay = vec[k].delay;
    done_cnt = 0; acked_cnt = 0; cs_rises = 0; stab_err = 0;
    start_load(vec[k].base);
    feed(vec[k].w, vec[k].nwords, vec[k].nwords > 2);
    t = 0;
    while (!(done || error) && t < 60) begin
      tick();
      t++;
    end
    if (!(done || error)) chk("completion_timeout", 0, 1);
    tick();
    chk($sformatf("v%0d_blocks_written", k), blocks_written, vec[k].exp_blocks);
    chk($sformatf("v%0d_done_pulses", k), done_cnt, vec[k].exp_done);
    chk($sformatf("v%0d_error", k), error, vec[k].exp_err);
    chk($sformatf("v%0d_busy_end", k), busy, 0);
    chk($sformatf("v%0d_in_ready_end", k), in_ready, 0);
    chk($sformatf("v%0d_acked_writes", k), acked_cnt, vec[k].exp_blocks);
    chk($sformatf("v%0d_cs_bursts", k), cs_rises, vec[k].exp_blocks);
    chk($sformatf("v%0d_cs_stable", k), stab_err, 0);
    rd_addr = vec[k].a0;
    #1 chk($sformatf("v%0d_ram_a0", k), rd_data, vec[k].d0);
    rd_addr = vec[k].a1;
    #1 chk($sformatf("v%0d_ram_a1", k), rd_data, vec[k].d1);
  endtask

  initial begin
    vec[0].base = 4'd3; vec[0].nwords = 4; vec[0].delay = 2'd0;
    vec[0].w[0] = 64'hA1A2A3A4A5A6A7A8; vec[0].w[1] = 64'hB1B2B3B4B5B6B7B8;
    vec[0].w[2] = 64'hC1C2C3C4C5C6C7C8; vec[0].w[3] = 64'hD1D2D3D4D5D6D7D8;
    vec[0].exp_blocks = 5'd2; vec[0].exp_done = 1'b1; vec[0].exp_err = 1'b0;
    vec[0].a0 = 4'd3; vec[0].d0 = {64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8};
    vec[0].a1 = 4'd4; vec[0].d1 = {64'hC1C2C3C4C5C6C7C8, 64'hD1D2D3D4D5D6D7D8};

    vec[1].base = 4'd0; vec[1].nwords = 3; vec[1].delay = 2'd0;
    vec[1].w[0] = 64'h0102030405060708; vec[1].w[1] = 64'h1112131415161718;
    vec[1].w[2] = 64'h1122334455667788; vec[1].w[3] = 64'h0;
    vec[1].exp_blocks = 5'd2; vec[1].exp_done = 1'b1; vec[1].exp_err = 1'b0;
    vec[1].a0 = 4'd0; vec[1].d0 = {64'h0102030405060708, 64'h1112131415161718};
    vec[1].a1 = 4'd1; vec[1].d1 = {64'h1122334455667788, 64'h0};

    vec[2].base = 4'd15; vec[2].nwords = 4; vec[2].delay = 2'd0;
    vec[2].w[0] = 64'hE1E2E3E4E5E6E7E8; vec[2].w[1] = 64'hF1F2F3F4F5F6F7F8;
    vec[2].w[2] = 64'h9192939495969798; vec[2].w[3] = 64'h8182838485868788;
    vec[2].exp_blocks = 5'd1; vec[2].exp_done = 1'b0; vec[2].exp_err = 1'b1;
    vec[2].a0 = 4'd15; vec[2].d0 = {64'hE1E2E3E4E5E6E7E8, 64'hF1F2F3F4F5F6F7F8};
    vec[2].a1 = 4'd0; vec[2].d1 = {64'h0102030405060708, 64'h1112131415161718};

    vec[3].base = 4'd6; vec[3].nwords = 2; vec[3].delay = 2'd3;
    vec[3].w[0] = 64'hCAFEBABE00000001; vec[3].w[1] = 64'hDEADBEEF00000002;
    vec[3].w[2] = 64'h0; vec[3].w[3] = 64'h0;
    vec[3].exp_blocks = 5'd1; vec[3].exp_done = 1'b1; vec[3].exp_err = 1'b0;
    vec[3].a0 = 4'd6; vec[3].d0 = {64'hCAFEBABE00000001, 64'hDEADBEEF00000002};
    vec[3].a1 = 4'd7; vec[3].d1 = 128'h0;

    vec[4].base = 4'd8; vec[4].nwords = 1; vec[4].delay = 2'd1;
    vec[4].w[0] = 64'h5555AAAA5555AAAA; vec[4].w[1] = 64'h0;
    vec[4].w[2] = 64'h0; vec[4].w[3] = 64'h0;
    vec[4].exp_blocks = 5'd1; vec[4].exp_done = 1'b1; vec[4].exp_err = 1'b0;
    vec[4].a0 = 4'd8; vec[4].d0 = {64'h5555AAAA5555AAAA, 64'h0};
    vec[4].a1 = 4'd9; vec[4].d1 = 128'h0;

    vec[5].base = 4'd12; vec[5].nwords = 2; vec[5].delay = 2'd0;
    vec[5].w[0] = 64'h0F0F0F0F0F0F0F0F; vec[5].w[1] = 64'hF0F0F0F0F0F0F0F0;
    vec[5].w[2] = 64'h0; vec[5].w[3] = 64'h0;
    vec[5].exp_blocks = 5'd1; vec[5].exp_done = 1'b1; vec[5].exp_err = 1'b0;
    vec[5].a0 = 4'd12; vec[5].d0 = {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};
    vec[5].a1 = 4'd10; vec[5].d1 = 128'h0;

    areset = 1'b1; ram_rst = 1'b1;
    start = 1'b0; base_addr = 4'd0; in_valid = 1'b0; in_data = 64'h0; in_last = 1'b0;
    ack_delay = 2'd0; rd_addr = 4'd0;
    prev_cs = 1'b0; prev_addr = 4'd0; prev_data = 128'h0;
    done_cnt = 0; acked_cnt = 0; cs_rises = 0; stab_err = 0;
    tick(); tick();
    areset = 1'b0; ram_rst = 1'b0;

    // Idle after reset: offered words are refused and nothing moves
    in_valid = 1'b1; in_data = 64'h123456789ABCDEF0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_in_ready", in_ready, 0);
    end
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_blocks", blocks_written, 0);
    chk("reset_cs", mem_cs, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_data", mem_block_wr, 0);
    chk("idle_no_cs_activity", cs_rises, 0);
    in_valid = 1'b0;

    for (int k = 0; k < 5; k++) run_load(k);

    // Reset while a delayed write is waiting for its ack
    ack_delay = 2'd3;
    start_load(4'd10);
    feed(vec[3].w, 2, 1'b0);
    chk("abort_cs_in_write", mem_cs, 1);
    tick();
    chk("abort_cs_in_wait", mem_cs, 1);
    areset = 1'b1;
    #1;
    chk("abort_cs", mem_cs, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_data", mem_block_wr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_blocks", blocks_written, 0);
    chk("abort_in_ready", in_ready, 0);
    tick();
    areset = 1'b0;
    tick();
    run_load(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
